relation_sequencer: RTL

RELATION_SEQUENCER -- requirements
Module: relation_sequencer

---
 rtl/relation_pkg.sv | 14 +
 rtl/pair_classifier.sv | 28 ++
 rtl/relation_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/relation_pkg.sv
// Shared definitions for the relation sequencer: FSM state encoding and the
// default counter width.
package relation_pkg;

  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pair_classifier.sv
// Combinational relation flags between a new sample a and the previous one b.
// Arithmetic is done one bit wider so 7 and 0 are never seen as adjacent.
module pair_classifier (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       gray,
  output logic       ex3,
  output logic       more,
  output logic       less,
  output logic       none
);

  logic [3:0] a_w;
  logic [3:0] b_w;
  logic [3:0] diff;

  always_comb begin
    a_w  = {1'b0, a};
    b_w  = {1'b0, b};
    diff = (a_w >= b_w) ? (a_w - b_w) : (b_w - a_w);
    gray = ($countones(a ^ b) == 1);
    ex3  = (diff == 4'd3);
    more = (a_w == b_w + 4'd1);
    less = (a_w + 4'd1 == b_w);
    none = !(gray || ex3 || more || less);
  end

endmodule

// File: rtl/relation_sequencer.sv
// Frames a stream of 3-bit samples, classifies each consecutive pair and
// reports per-relation counts once frame_len pairs have been seen.
module relation_sequencer
  import relation_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [2:0]       s_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [LEN_W-1:0] cnt_gray,
  output logic [LEN_W-1:0] cnt_ex3,
  output logic [LEN_W-1:0] cnt_more,
  output logic [LEN_W-1:0] cnt_less,
  output logic [LEN_W-1:0] cnt_none,
  output logic             busy
);

  seq_state_t       state;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] pair_cnt;
  logic [2:0]       prev;
  logic             f_gray, f_ex3, f_more, f_less, f_none;
  logic             beat;

  pair_classifier u_classifier (
    .a    (s_data),
    .b    (prev),
    .gray (f_gray),
    .ex3  (f_ex3),
    .more (f_more),
    .less (f_less),
    .none (f_none)
  );

  assign beat = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      r_valid  <= 1'b0;
      busy     <= 1'b0;
      len_reg  <= '0;
      pair_cnt <= '0;
      prev     <= '0;
      cnt_gray <= '0;
      cnt_ex3  <= '0;
      cnt_more <= '0;
      cnt_less <= '0;
      cnt_none <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            len_reg  <= frame_len;
            pair_cnt <= '0;
            cnt_gray <= '0;
            cnt_ex3  <= '0;
            cnt_more <= '0;
            cnt_less <= '0;
            cnt_none <= '0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            state    <= PRIME;
          end
        end
        PRIME: begin
          if (beat) begin
            prev  <= s_data;
            state <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            cnt_gray <= cnt_gray + LEN_W'(f_gray);
            cnt_ex3  <= cnt_ex3  + LEN_W'(f_ex3);
            cnt_more <= cnt_more + LEN_W'(f_more);
            cnt_less <= cnt_less + LEN_W'(f_less);
            cnt_none <= cnt_none + LEN_W'(f_none);
            prev     <= s_data;
            pair_cnt <= pair_cnt + LEN_W'(1);
            // Outputs are registered, so r_valid appears the cycle after the last beat.
            if (LEN_W'(pair_cnt + LEN_W'(1)) == len_reg) begin
              s_ready <= 1'b0;
              r_valid <= 1'b1;
              state   <= REPORT;
            end
          end
        end
        REPORT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          r_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
